universal_shift_reg_n: RTL and testbench

//  Parametrised N-bit universal shift register: next generation of our 4-bit hold/shift/load stage chain.

---
 rtl/shift_reg_pkg.sv | 27 ++
 rtl/usr_shift_step.sv | 32 +++
 rtl/universal_shift_reg_n.sv | 106 ++++++++++
 tb/tb_universal_shift_reg_n.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// burst FSM states and the burst-capable mode test.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;
  localparam logic [2:0] MODE_ASHR = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Only position-moving modes can be repeated as a burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    case (m)
      MODE_SHR, MODE_SHL, MODE_ROTR, MODE_ROTL, MODE_ASHR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One step of the universal shift register: next contents for a given mode.
// Used by both the continuous path and the burst path.
module usr_shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       mode,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic [WIDTH-1:0] i_par,
  output logic [WIDTH-1:0] next_a
);

  // Next-value selection; hold and reserved encodings keep the contents.
  always_comb begin
    next_a = a;
    case (mode)
      MODE_HOLD: next_a = a;
      MODE_SHR:  next_a = {msb_in, a[WIDTH-1:1]};
      MODE_SHL:  next_a = {a[WIDTH-2:0], lsb_in};
      MODE_LOAD: next_a = i_par;
      MODE_ROTR: next_a = {a[0], a[WIDTH-1:1]};
      MODE_ROTL: next_a = {a[WIDTH-2:0], a[WIDTH-1]};
      MODE_ASHR: next_a = {a[WIDTH-1], a[WIDTH-1:1]};
      MODE_RSVD: next_a = a;
      default:   next_a = a;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// N-bit universal shift register with continuous operation and a counted
// burst mode (busy/done handshake) built on a shared single-step datapath.
module universal_shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] A_par,
  output logic             MSB_out,
  output logic             LSB_out,
  output logic             busy,
  output logic             done
);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       mode_r;
  logic [WIDTH-1:0] a_r;
  logic             busy_r;
  logic             done_r;
  logic [2:0]       step_mode_s;
  logic [WIDTH-1:0] step_a_s;

  // A running burst uses its latched mode; otherwise the live mode applies.
  always_comb begin
    step_mode_s = mode;
    if (state_r == RUN) begin
      step_mode_s = mode_r;
    end else begin
      step_mode_s = mode;
    end
  end

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_r),
    .mode   (step_mode_s),
    .msb_in (MSB_in),
    .lsb_in (LSB_in),
    .i_par  (I_par),
    .next_a (step_a_s)
  );

  // Data register, step counter and burst FSM with registered busy/done.
  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      mode_r  <= MODE_HOLD;
      a_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (amt == {CNT_W{1'b0}}) begin
              done_r <= 1'b1;
            end else if (is_burst_mode(mode)) begin
              // Latch only; the first step happens on the next edge.
              mode_r  <= mode;
              cnt_r   <= amt;
              state_r <= RUN;
              busy_r  <= 1'b1;
            end else begin
              a_r    <= step_a_s;
              done_r <= 1'b1;
            end
          end else begin
            a_r <= step_a_s;
          end
        end
        RUN: begin
          a_r   <= step_a_s;
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign A_par   = a_r;
  assign MSB_out = a_r[WIDTH-1];
  assign LSB_out = a_r[0];
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Self-checking bench for universal_shift_reg_n: directed scenarios plus
// random traffic, all checked against an arithmetic reference model.
module tb_universal_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int FULL  = 2 ** WIDTH;
  localparam int HALF  = 2 ** (WIDTH - 1);

  logic             CLK;
  logic             Clear_b;
  logic [2:0]       mode;
  logic [WIDTH-1:0] I_par;
  logic             MSB_in;
  logic             LSB_in;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] A_par;
  logic             MSB_out;
  logic             LSB_out;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: value, remaining burst steps, burst op, flags.
  int       m_a    = 0;
  int       m_rem  = 0;
  int       m_op   = 0;
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;

  universal_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK     (CLK),
    .Clear_b (Clear_b),
    .mode    (mode),
    .I_par   (I_par),
    .MSB_in  (MSB_in),
    .LSB_in  (LSB_in),
    .start   (start),
    .amt     (amt),
    .A_par   (A_par),
    .MSB_out (MSB_out),
    .LSB_out (LSB_out),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Plain integer arithmetic view of each operation.
  function automatic int ref_op(input int a, input int op, input int mi, input int li, input int ip);
    case (op)
      1:       return a / 2 + mi * HALF;
      2:       return (a * 2 + li) % FULL;
      3:       return ip;
      4:       return a / 2 + (a % 2) * HALF;
      5:       return (a * 2) % FULL + a / HALF;
      6:       return a / 2 + ((a >= HALF) ? HALF : 0);
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit clr, input int md, input int ip, input bit mi, input bit li,
                       input bit st, input int am);
    Clear_b = clr;
    mode    = md[2:0];
    I_par   = ip[WIDTH-1:0];
    MSB_in  = mi;
    LSB_in  = li;
    start   = st;
    amt     = am[CNT_W-1:0];
    if (!clr) begin
      m_a = 0; m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_a    = ref_op(m_a, m_op, int'(mi), int'(li), ip);
      m_rem  = m_rem - 1;
      m_busy = (m_rem > 0);
      m_done = (m_rem == 0);
    end else if (st && am == 0) begin
      m_done = 1'b1;
    end else if (st && (md inside {1, 2, 4, 5, 6})) begin
      m_op = md; m_rem = am; m_busy = 1'b1; m_done = 1'b0;
    end else begin
      m_a    = ref_op(m_a, md, int'(mi), int'(li), ip);
      m_done = st;
    end
    @(posedge CLK);
    #1;
    chk("A_par", {24'd0, A_par}, m_a);
    chk("MSB_out", {31'd0, MSB_out}, m_a / HALF);
    chk("LSB_out", {31'd0, LSB_out}, m_a % 2);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
  endtask

  initial begin
    Clear_b = 1'b0; mode = 3'd0; I_par = 8'h00; MSB_in = 1'b0; LSB_in = 1'b0;
    start = 1'b0; amt = 4'd0;

    // Reset during activity, then stable between edges.
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 3, 'h5A, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 3, 'hFF, 1'b1, 1'b1, 1'b1, 5);
    chk("t1_reset_a", {24'd0, A_par}, 32'h00);
    @(negedge CLK);
    chk("t1_stable_a", {24'd0, A_par}, 32'h00);
    chk("t1_stable_busy", {31'd0, busy}, 32'd0);

    // Load, shift right/left, hold.
    cycle(1'b1, 3, 'hA5, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 0);
    chk("t2_shr", {24'd0, A_par}, 32'hD2);
    cycle(1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 0);
    chk("t2_shl", {24'd0, A_par}, 32'hA4);
    cycle(1'b1, 0, 'hFF, 1'b1, 1'b1, 1'b0, 0);
    chk("t2_hold", {24'd0, A_par}, 32'hA4);

    // Arithmetic shift and rotates.
    cycle(1'b1, 3, 'h90, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 6, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t3_ashr", {24'd0, A_par}, 32'hC8);
    cycle(1'b1, 3, 'h81, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t3_rotr", {24'd0, A_par}, 32'hC0);
    cycle(1'b1, 3, 'h81, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t3_rotl", {24'd0, A_par}, 32'h03);

    // Burst ROTL x3, with a start during busy that must be ignored.
    cycle(1'b1, 3, 'h81, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 5, 0, 1'b0, 1'b0, 1'b1, 3);
    chk("t4_busy0", {31'd0, busy}, 32'd1);
    cycle(1'b1, 3, 'hFF, 1'b0, 1'b0, 1'b1, 7);
    cycle(1'b1, 1, 'hFF, 1'b1, 1'b1, 1'b1, 2);
    chk("t4_busy2", {31'd0, busy}, 32'd1);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_result", {24'd0, A_par}, 32'h0C);
    chk("t4_done", {31'd0, done}, 32'd1);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_done_once", {31'd0, done}, 32'd0);

    // Burst ROTR x9 wraps modulo width; amt=0 start.
    cycle(1'b1, 3, 'h01, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 4, 0, 1'b0, 1'b0, 1'b1, 9);
    for (int i = 0; i < 9; i++) cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t5_rotr9", {24'd0, A_par}, 32'h80);
    cycle(1'b1, 1, 'h33, 1'b1, 1'b1, 1'b1, 0);
    chk("t5_amt0_a", {24'd0, A_par}, 32'h80);
    chk("t5_amt0_done", {31'd0, done}, 32'd1);

    // Reset aborts an amt=5 burst; a fresh burst then completes.
    cycle(1'b1, 3, 'h0F, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 2, 0, 1'b0, 1'b1, 1'b1, 5);
    cycle(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    chk("t6_abort_a", {24'd0, A_par}, 32'h00);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_no_done", {31'd0, done}, 32'd0);
    cycle(1'b1, 2, 0, 1'b0, 1'b1, 1'b1, 4);
    for (int i = 0; i < 4; i++) cycle(1'b1, 7, 0, 1'b1, 1'b1, 1'b0, 0);
    chk("t6_new_burst", {24'd0, A_par}, 32'h0F);

    // Random traffic, including long bursts and occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 24) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
